cpu_mul_pipe: RTL and testbench

//  Responder side of the execute-stage multiply interface: accepts operands and destination id

---
 rtl/cpu_mul_pipe_if.sv | 33 +++
 rtl/cpu_mul_pipe.sv | 91 +++++++++
 tb/tb_cpu_mul_pipe.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_mul_pipe_if.sv
// Execute-stage multiply bus: request, pipeline control, HDU lookup and writeback result.
// Signal prefixes (i_/o_) are from the multiplier's point of view.
interface cpu_mul_pipe_if #(
  parameter int REG_WIDTH    = 32,
  parameter int REG_ID_WIDTH = 5
);
  logic                    i_req_valid;
  logic [REG_WIDTH-1:0]    i_ra_data;
  logic [REG_WIDTH-1:0]    i_rb_data;
  logic [REG_ID_WIDTH-1:0] i_rd_id;
  logic                    i_stall;
  logic                    i_flush;
  logic [REG_ID_WIDTH-1:0] i_query_ra_id;
  logic [REG_ID_WIDTH-1:0] i_query_rb_id;
  logic                    o_ra_pending;
  logic                    o_rb_pending;
  logic                    o_wb_valid_mul;
  logic [REG_ID_WIDTH-1:0] o_wb_rd_mul;
  logic [REG_WIDTH-1:0]    o_wb_value_mul;
  logic                    o_busy;

  modport master (
    output i_req_valid, i_ra_data, i_rb_data, i_rd_id, i_stall, i_flush,
           i_query_ra_id, i_query_rb_id,
    input  o_ra_pending, o_rb_pending, o_wb_valid_mul, o_wb_rd_mul, o_wb_value_mul, o_busy
  );

  modport slave (
    input  i_req_valid, i_ra_data, i_rb_data, i_rd_id, i_stall, i_flush,
           i_query_ra_id, i_query_rb_id,
    output o_ra_pending, o_rb_pending, o_wb_valid_mul, o_wb_rd_mul, o_wb_value_mul, o_busy
  );
endinterface

// File: rtl/cpu_mul_pipe.sv
// Fixed-latency pipelined multiplier (low word of the product) for the execute stage,
// with in-flight destination lookup for hazard detection.
module cpu_mul_pipe #(
  parameter int REG_WIDTH    = 32,
  parameter int REG_ID_WIDTH = 5,
  parameter int STAGES       = 4
) (
  input logic           clock,
  input logic           reset,
  cpu_mul_pipe_if.slave bus
);

  localparam int HALF = REG_WIDTH / 2;

  logic [STAGES:1]                   r_valid;
  logic [STAGES:1][REG_ID_WIDTH-1:0] r_rd;
  logic [STAGES:2][REG_WIDTH-1:0]    r_data;
  logic [REG_WIDTH-1:0]              r_ll;
  logic [HALF-1:0]                   r_lh;
  logic [HALF-1:0]                   r_hl;

  logic [HALF-1:0]      w_a_lo;
  logic [HALF-1:0]      w_a_hi;
  logic [HALF-1:0]      w_b_lo;
  logic [HALF-1:0]      w_b_hi;
  logic [REG_WIDTH-1:0] w_ll;
  logic [HALF-1:0]      w_lh;
  logic [HALF-1:0]      w_hl;
  logic [HALF-1:0]      w_cross;
  logic [REG_WIDTH-1:0] w_sum;
  logic                 w_ra_pending;
  logic                 w_rb_pending;

  assign w_a_lo = bus.i_ra_data[HALF-1:0];
  assign w_a_hi = bus.i_ra_data[REG_WIDTH-1:HALF];
  assign w_b_lo = bus.i_rb_data[HALF-1:0];
  assign w_b_hi = bus.i_rb_data[REG_WIDTH-1:HALF];

  // Cross terms only contribute their low half to the low word; HH never reaches it.
  assign w_ll    = {{HALF{1'b0}}, w_a_lo} * {{HALF{1'b0}}, w_b_lo};
  assign w_lh    = w_a_lo * w_b_hi;
  assign w_hl    = w_a_hi * w_b_lo;
  assign w_cross = r_lh + r_hl;
  assign w_sum   = r_ll + {w_cross, {HALF{1'b0}}};

  // Pipeline registers: reset, then flush (even under stall), then advance when not stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      r_rd    <= '0;
      r_data  <= '0;
      r_ll    <= '0;
      r_lh    <= '0;
      r_hl    <= '0;
    end else if (bus.i_flush) begin
      r_valid <= '0;
    end else if (!bus.i_stall) begin
      r_valid[1] <= bus.i_req_valid;
      r_rd[1]    <= bus.i_rd_id;
      r_ll       <= w_ll;
      r_lh       <= w_lh;
      r_hl       <= w_hl;
      for (int k = 2; k <= STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_rd[k]    <= r_rd[k-1];
      end
      r_data[2] <= w_sum;
      for (int k = 3; k <= STAGES; k++) begin
        r_data[k] <= r_data[k-1];
      end
    end
  end

  // Output stage is excluded: its result is already forwarded on the wb_* bus.
  always_comb begin
    w_ra_pending = 1'b0;
    w_rb_pending = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      w_ra_pending = w_ra_pending | (r_valid[k] & (r_rd[k] == bus.i_query_ra_id));
      w_rb_pending = w_rb_pending | (r_valid[k] & (r_rd[k] == bus.i_query_rb_id));
    end
  end

  assign bus.o_ra_pending   = w_ra_pending;
  assign bus.o_rb_pending   = w_rb_pending;
  assign bus.o_wb_valid_mul = r_valid[STAGES];
  assign bus.o_wb_rd_mul    = r_rd[STAGES];
  assign bus.o_wb_value_mul = r_data[STAGES];
  assign bus.o_busy         = |r_valid;

endmodule

// File: tb/tb_cpu_mul_pipe.sv
// Directed bench for cpu_mul_pipe: a scoreboard queue predicts result timing, ids and values,
// plus hazard-lookup and busy indications, cycle by cycle.
module tb_cpu_mul_pipe;

  localparam int W  = 32;
  localparam int ID = 5;
  localparam int ST = 4;

  logic clock;
  logic reset;

  cpu_mul_pipe_if #(.REG_WIDTH(W), .REG_ID_WIDTH(ID)) bus ();

  cpu_mul_pipe #(.REG_WIDTH(W), .REG_ID_WIDTH(ID), .STAGES(ST)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [ID-1:0] rd;
    logic [W-1:0]  val;
    int            due;
  } sb_t;

  sb_t           q[$];
  int            errors = 0;
  int            checks = 0;
  int            edge_n = 0;
  logic [W-1:0]  cur_exp = '0;
  logic          exp_v = 1'b0;
  logic [ID-1:0] exp_rd = '0;
  logic [W-1:0]  exp_val = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic req(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [ID-1:0] rd, input logic [W-1:0] e);
    bus.i_req_valid = v;
    bus.i_ra_data   = a;
    bus.i_rb_data   = b;
    bus.i_rd_id     = rd;
    cur_exp         = e;
  endtask

  // One clock edge: update the scoreboard from the inputs presented, then check all outputs.
  task automatic step();
    logic rs, fl, st, pa, pb;
    sb_t  e;
    rs = reset;
    fl = bus.i_flush;
    st = bus.i_stall;
    if (!rs && !fl && st) begin
      foreach (q[i]) q[i].due++;
    end
    if (!rs && !fl && !st && bus.i_req_valid) begin
      e.rd  = bus.i_rd_id;
      e.val = cur_exp;
      e.due = edge_n + ST;
      q.push_back(e);
    end
    @(posedge clock);
    #1;
    edge_n++;
    if (rs || fl) begin
      q.delete();
      exp_v = 1'b0;
    end else if (!st) begin
      if (q.size() > 0 && q[0].due == edge_n) begin
        e       = q.pop_front();
        exp_v   = 1'b1;
        exp_rd  = e.rd;
        exp_val = e.val;
      end else begin
        exp_v = 1'b0;
      end
    end
    chk("wb_valid", {31'd0, bus.o_wb_valid_mul}, {31'd0, exp_v});
    if (exp_v) begin
      chk("wb_rd", {27'd0, bus.o_wb_rd_mul}, {27'd0, exp_rd});
      chk("wb_value", bus.o_wb_value_mul, exp_val);
    end
    pa = 1'b0;
    pb = 1'b0;
    foreach (q[i]) begin
      if (q[i].rd == bus.i_query_ra_id) pa = 1'b1;
      if (q[i].rd == bus.i_query_rb_id) pb = 1'b1;
    end
    chk("ra_pending", {31'd0, bus.o_ra_pending}, {31'd0, pa});
    chk("rb_pending", {31'd0, bus.o_rb_pending}, {31'd0, pb});
    chk("busy", {31'd0, bus.o_busy}, {31'd0, (q.size() > 0) || exp_v});
  endtask

  initial begin
    reset             = 1'b1;
    bus.i_stall       = 1'b0;
    bus.i_flush       = 1'b0;
    bus.i_query_ra_id = 5'd2;
    bus.i_query_rb_id = 5'd0;
    req(1'b1, 32'd7, 32'd6, 5'd3, 32'd42);

    // Reset with a request pending: nothing may be accepted.
    step();
    step();
    chk("reset_wb_rd", {27'd0, bus.o_wb_rd_mul}, 32'd0);
    chk("reset_wb_value", bus.o_wb_value_mul, 32'd0);
    reset = 1'b0;
    req(1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    step();

    // Single op.
    req(1'b1, 32'd7, 32'd6, 5'd3, 32'd42);
    step();
    req(1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    repeat (4) step();

    // Wrap and width cases; rd=0 exercises a zero query id.
    req(1'b1, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'hFFFF_FFFE);
    step();
    req(1'b1, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'h0000_0000);
    step();
    req(1'b1, 32'h0001_FFFF, 32'h0001_0003, 5'd6, 32'h0004_FFFD);
    step();
    req(1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    repeat (4) step();

    // Back-to-back, query 2 tracks op 2 through the pipe.
    for (int i = 1; i <= 4; i++) begin
      req(1'b1, W'(i), W'(i), ID'(i), W'(i * i));
      step();
    end
    req(1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    repeat (5) step();

    // Stall for 3 cycles with a result on the output and one still in flight.
    bus.i_query_ra_id = 5'd8;
    bus.i_query_rb_id = 5'd9;
    req(1'b1, 32'd3, 32'd5, 5'd7, 32'd15);
    step();
    req(1'b1, 32'd4, 32'd4, 5'd8, 32'd16);
    step();
    req(1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    step();
    step();
    bus.i_stall = 1'b1;
    req(1'b1, 32'd9, 32'd9, 5'd9, 32'd81);
    repeat (3) step();
    bus.i_stall = 1'b0;
    req(1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    repeat (3) step();

    // Flush with stall and a same-cycle request: everything disappears.
    bus.i_query_ra_id = 5'd10;
    bus.i_query_rb_id = 5'd12;
    req(1'b1, 32'd2, 32'd3, 5'd10, 32'd6);
    step();
    req(1'b1, 32'd3, 32'd3, 5'd11, 32'd9);
    step();
    bus.i_flush = 1'b1;
    bus.i_stall = 1'b1;
    req(1'b1, 32'd5, 32'd5, 5'd12, 32'd25);
    step();
    bus.i_flush = 1'b0;
    bus.i_stall = 1'b0;
    req(1'b0, 32'd0, 32'd0, 5'd0, 32'd0);
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
